// File: rtl/jump_target_ras_if.sv
// Decode-stage jump resolver bus.
// Carries the decode-stage instruction fields and hazard status into the
// resolver, and the fetch redirect, stall request, RAS view and statistics
// counters back out.
//   master : the decode stage (drives instruction fields, observes results)
//   slave  : the jump resolver itself
interface jump_target_ras_if #(
  parameter int ADDR_W    = 32,
  parameter int TARGET_W  = 26,
  parameter int RAS_DEPTH = 8,
  parameter int CNT_W     = 16
);
  localparam int RC_W = $clog2(RAS_DEPTH) + 1;

  logic                ValidD;
  logic                StallD;
  logic                FlushD;
  logic [5:0]          OpCode;
  logic [5:0]          Funct;
  logic [4:0]          RsAddr;
  logic [TARGET_W-1:0] Target;
  logic [ADDR_W-1:0]   PCPlus4D;
  logic [ADDR_W-1:0]   RsValue;
  logic                RsReady;

  logic                JumpTaken;
  logic [ADDR_W-1:0]   JumpAddress;
  logic                JumpStall;
  logic [ADDR_W-1:0]   RasTop;
  logic [RC_W-1:0]     RasCount;
  logic [CNT_W-1:0]    JumpCount;
  logic [CNT_W-1:0]    RasMissCount;

  modport master (
    output ValidD, StallD, FlushD, OpCode, Funct, RsAddr, Target,
           PCPlus4D, RsValue, RsReady,
    input  JumpTaken, JumpAddress, JumpStall, RasTop, RasCount,
           JumpCount, RasMissCount
  );

  modport slave (
    input  ValidD, StallD, FlushD, OpCode, Funct, RsAddr, Target,
           PCPlus4D, RsValue, RsReady,
    output JumpTaken, JumpAddress, JumpStall, RasTop, RasCount,
           JumpCount, RasMissCount
  );
endinterface

// File: rtl/jump_target_ras.sv
// Decode-stage jump resolver with return-address stack.
// Resolves j/jal/jr/jalr targets combinationally for the fetch redirect,
// requests a stall while a jr/jalr source register is still pending, keeps a
// circular return-address stack and counts jumps and RAS mispredictions.
// Ports:
//   clk   : pipeline clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : jump_target_ras_if slave (instruction fields in, redirect,
//           stall, RAS top/occupancy and statistics out)
module jump_target_ras #(
  parameter int ADDR_W    = 32,
  parameter int TARGET_W  = 26,
  parameter int RAS_DEPTH = 8,
  parameter int CNT_W     = 16
) (
  input logic              clk,
  input logic              rst_n,
  jump_target_ras_if.slave bus
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int RC_W  = PTR_W + 1;
  localparam logic [RC_W-1:0] RAS_FULL = RC_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] rasMem [RAS_DEPTH];
  logic [PTR_W-1:0]  tp;
  logic [RC_W-1:0]   cnt;
  logic [CNT_W-1:0]  jumpCnt;
  logic [CNT_W-1:0]  missCnt;

  logic isJ, isJal, isJr, isJalr, act, stall, taken, fire;
  logic doPop, doPush, miss;
  logic [ADDR_W-1:0] rasTop;
  logic [PTR_W-1:0]  tpPop, tpNext;
  logic [RC_W-1:0]   cntPop, cntNext;

  // Instruction decode and the combinational fetch redirect. The target is
  // forced to zero when no redirect happens so fetch never sees a stale value.
  always_comb begin
    isJ    = (bus.OpCode == 6'b000010);
    isJal  = (bus.OpCode == 6'b000011);
    isJr   = (bus.OpCode == 6'b000000) && (bus.Funct == 6'b001000);
    isJalr = (bus.OpCode == 6'b000000) && (bus.Funct == 6'b001001);
    act    = bus.ValidD && !bus.FlushD && (isJ || isJal || isJr || isJalr);
    stall  = act && (isJr || isJalr) && !bus.RsReady;
    taken  = act && !stall;
    fire   = taken && !bus.StallD;
    rasTop = (cnt != '0) ? rasMem[tp] : '0;

    if (!taken)
      bus.JumpAddress = '0;
    else if (isJ || isJal)
      bus.JumpAddress = {bus.PCPlus4D[ADDR_W-1:TARGET_W+2], bus.Target, 2'b00};
    else
      bus.JumpAddress = bus.RsValue;
  end

  // A return is any register jump through $31. A jalr $31 both pops and
  // pushes, so the push is applied on top of the already-popped pointer:
  // with a non-empty stack this nets out to overwriting the top entry.
  // Popping an empty stack leaves the pointer alone and is always a miss.
  always_comb begin
    doPop  = fire && (isJr || isJalr) && (bus.RsAddr == 5'd31);
    doPush = fire && (isJal || isJalr);
    miss   = doPop && ((cnt == '0) || (rasTop != bus.RsValue));

    tpPop  = tp;
    cntPop = cnt;
    if (doPop && (cnt != '0)) begin
      tpPop  = tp - PTR_W'(1);
      cntPop = cnt - RC_W'(1);
    end

    tpNext  = tpPop;
    cntNext = cntPop;
    if (doPush) begin
      tpNext  = tpPop + PTR_W'(1);
      cntNext = (cntPop == RAS_FULL) ? RAS_FULL : cntPop + RC_W'(1);
    end
  end

  // State only moves on a committed jump; a full stack simply wraps and
  // loses its oldest entry. Both statistics counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tp      <= '0;
      cnt     <= '0;
      jumpCnt <= '0;
      missCnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++)
        rasMem[i] <= '0;
    end else if (fire) begin
      tp  <= tpNext;
      cnt <= cntNext;
      if (doPush)
        rasMem[tpNext] <= bus.PCPlus4D;
      if (jumpCnt != '1)
        jumpCnt <= jumpCnt + CNT_W'(1);
      if (miss && (missCnt != '1))
        missCnt <= missCnt + CNT_W'(1);
    end
  end

  assign bus.JumpTaken    = taken;
  assign bus.JumpStall    = stall;
  assign bus.RasTop       = rasTop;
  assign bus.RasCount     = cnt;
  assign bus.JumpCount    = jumpCnt;
  assign bus.RasMissCount = missCnt;
endmodule

// File: doc/jump_target_ras.md
Name: jump_target_ras

Overview:
- Decode-stage jump resolver for the 5-stage MIPS pipeline; the parametrised successor of the single-width jump address unit.
- Resolves j, jal, jr and jalr targets combinationally for the fetch redirect.
- Adds a circular return-address stack (RAS), a stall request while the jr/jalr source register is unresolved, and saturating jump/mismatch statistics counters.

Parameters:
- ADDR_W, 32, PC/address width (must be >= TARGET_W+2).
- TARGET_W, 26, J-format target field width.
- RAS_DEPTH, 8, RAS entries (power of two, >= 2).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ValidD  in  1  decode-stage instruction valid.
- StallD  in  1  decode stage held this cycle.
- FlushD  in  1  decode instruction squashed.
- OpCode  in  6  instruction [31:26].
- Funct  in  6  instruction [5:0].
- RsAddr  in  5  rs register index.
- Target  in  TARGET_W  J-format target field.
- PCPlus4D  in  ADDR_W  PC+4 of the decode instruction.
- RsValue  in  ADDR_W  forwarded rs value.
- RsReady  in  1  RsValue is final (no pending hazard).
- JumpTaken  out  1  redirect fetch this cycle.
- JumpAddress  out  ADDR_W  redirect target.
- JumpStall  out  1  jr/jalr waiting on RsReady.
- RasTop  out  ADDR_W  current top entry (0 when empty).
- RasCount  out  $clog2(RAS_DEPTH)+1  occupancy.
- JumpCount  out  CNT_W  retired jumps, saturating.
- RasMissCount  out  CNT_W  jr $31 mismatches/underflows, saturating.

Behaviour:
- Decode: J = OpCode 000010; JAL = 000011; JR = OpCode 000000 && Funct 001000; JALR = OpCode 000000 && Funct 001001. Any other encoding is not a jump.
- act = ValidD && !FlushD && (J|JAL|JR|JALR).
- Combinational outputs:
  - JumpTaken = act && !JumpStall.
  - J/JAL: JumpAddress = {PCPlus4D[ADDR_W-1:TARGET_W+2], Target, 2'b00}.
  - JR/JALR: JumpAddress = RsValue.
  - JumpAddress = 0 when not taken (no latching of the previous value).
  - JumpStall = act && (JR|JALR) && !RsReady.
- Commit condition: fire = JumpTaken && !StallD. All state updates occur only on a fire edge; stalled, flushed or invalid cycles change nothing.
- RAS is a circular buffer with top pointer tp and count cnt.
- Push (JAL, JALR on fire): tp <= tp+1 mod RAS_DEPTH; entry[tp+1] <= PCPlus4D; cnt <= min(cnt+1, RAS_DEPTH). A push when full overwrites the oldest entry and cnt stays at RAS_DEPTH.
- Pop (JR or JALR with RsAddr==31, on fire):
  - cnt>0: tp <= tp-1 mod RAS_DEPTH; cnt <= cnt-1.
  - cnt==0: no pointer change, cnt stays 0, no wrap; counts as a miss.
- Miss: pop with cnt==0, or pop with RasTop != RsValue. RasMissCount increments, saturating at all-ones. The pop still occurs on a mismatch.
- JALR with RsAddr==31: pop, then push in the same edge. Net effect: the top entry is replaced by PCPlus4D and cnt is unchanged. If cnt==0, the miss is counted and cnt becomes 1.
- JumpCount increments on every fire, saturating.
- RasTop = entry[tp] when cnt>0, else 0.
- Reset (asynchronous, any time, including mid-stall): tp=0, cnt=0, all entries=0, both counters=0. Combinational outputs follow their inputs. After reset: RasTop=0, RasCount=0.

Test Plan:
- Reset then J with PCPlus4D=0x40000010, Target=0x0000100 -> JumpTaken=1, JumpAddress=0x40000400; JumpCount=1 after the edge; RasCount stays 0.
- JAL at PCPlus4D=0x00400008, then JR RsAddr=31, RsValue=0x00400008 -> RasCount 1 then 0; RasTop=0x00400008 before the pop; RasMissCount=0.
- JR $31 with RsReady=0 for 3 cycles, then 1 -> JumpStall=1 and JumpTaken=0 for 3 cycles; single pop on the 4th cycle; JumpCount +1 only.
- Nine JALs with RAS_DEPTH=8 (PCPlus4D 0x04,0x08,...,0x24) -> RasCount=8, RasTop=0x24; eight pops return 0x24..0x08; the ninth pop is an underflow, RasMissCount=1, RasCount=0.
- JAL with StallD=1 for 2 cycles, and a JAL with FlushD=1 -> no RAS or counter change until the unstalled edge; the flushed JAL has JumpTaken=0 and no effect.
- Two pushes, then assert rst_n=0 mid-cycle asynchronously -> RasCount=0, RasTop=0, JumpCount=0 immediately, without waiting for a clock edge.
